// File: rtl/sprite_slot_writer.sv
// ---------------------------------------------------------------------------
// sprite_slot_writer
//
// Bus initiator for the video-slot write port of one sprite core. It takes
// high-level commands (set position, set ctrl, set bypass, bitmap upload)
// and turns each into single-cycle slot writes. Bitmap pixels arrive on a
// valid/ready stream and are written to consecutive sprite RAM addresses.
//
// Ports:
//   clk, reset           system clock, synchronous active-low reset
//   frame_tick           one-cycle pulse at start of vertical blank
//   cmd_valid/cmd_ready  command handshake; cmd_op selects the operation
//   cmd_x, cmd_y         sprite origin for SET_POS
//   cmd_val              ctrl value (SET_CTRL) / bypass in bit 0 (SET_BYPASS)
//   cmd_base, cmd_len    first RAM address and pixel count for UPLOAD
//   px_valid/px_ready    pixel stream handshake, px_data is the pixel code
//   cs, write, addr,
//   wr_data              registered slot write interface (write == cs)
//   busy                 high whenever the writer is not idle
//   done                 one-cycle pulse when a command completes
// ---------------------------------------------------------------------------
module sprite_slot_writer #(
  parameter int ADDR_WIDTH = 13,
  parameter int SYNC_POS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [10:0]           cmd_x,
  input  logic [10:0]           cmd_y,
  input  logic [4:0]            cmd_val,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic                  px_valid,
  output logic                  px_ready,
  input  logic [1:0]            px_data,
  output logic                  cs,
  output logic                  write,
  output logic [13:0]           addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SYNC_WAIT = 3'd1;
  localparam logic [2:0] S_WR_X      = 3'd2;
  localparam logic [2:0] S_WR_Y      = 3'd3;
  localparam logic [2:0] S_WR_REG    = 3'd4;
  localparam logic [2:0] S_UPLOAD    = 3'd5;
  localparam logic [2:0] S_FIN       = 3'd6;

  localparam logic [1:0] OP_SET_POS    = 2'd0;
  localparam logic [1:0] OP_SET_CTRL   = 2'd1;
  localparam logic [1:0] OP_SET_BYPASS = 2'd2;

  localparam logic [13:0] REG_BYPASS = 14'h2000;
  localparam logic [13:0] REG_X0     = 14'h2001;
  localparam logic [13:0] REG_Y0     = 14'h2002;
  localparam logic [13:0] REG_CTRL   = 14'h2003;

  logic [2:0]            state_q,   state_d;
  logic [10:0]           x_q,       x_d;
  logic [10:0]           y_q,       y_d;
  logic [ADDR_WIDTH-1:0] ptr_q,     ptr_d;
  logic [ADDR_WIDTH:0]   rem_q,     rem_d;
  logic                  cs_q,      cs_d;
  logic [13:0]           addr_q,    addr_d;
  logic [31:0]           wr_data_q, wr_data_d;

  // Handshakes are qualified with reset so nothing is accepted (and no
  // pixel is consumed) in a cycle where reset is being applied.
  assign cmd_ready = reset && (state_q == S_IDLE);
  assign px_ready  = reset && (state_q == S_UPLOAD) && (rem_q != '0);

  assign cs      = cs_q;
  assign write   = cs_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FIN);

  // Bus registers are loaded on the same edge the FSM enters the state that
  // owns the write, so the write is visible in that state's cycle.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    cs_d      = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          case (cmd_op)
            OP_SET_POS: begin
              x_d = cmd_x;
              y_d = cmd_y;
              if (SYNC_POS != 0) begin
                state_d = S_SYNC_WAIT;
              end else begin
                state_d   = S_WR_X;
                cs_d      = 1'b1;
                addr_d    = REG_X0;
                wr_data_d = {21'd0, cmd_x};
              end
            end
            OP_SET_CTRL: begin
              state_d   = S_WR_REG;
              cs_d      = 1'b1;
              addr_d    = REG_CTRL;
              wr_data_d = {27'd0, cmd_val};
            end
            OP_SET_BYPASS: begin
              state_d   = S_WR_REG;
              cs_d      = 1'b1;
              addr_d    = REG_BYPASS;
              wr_data_d = {31'd0, cmd_val[0]};
            end
            default: begin
              ptr_d   = cmd_base;
              rem_d   = cmd_len;
              state_d = (cmd_len == '0) ? S_FIN : S_UPLOAD;
            end
          endcase
        end
      end
      S_SYNC_WAIT: begin
        if (frame_tick) begin
          state_d   = S_WR_X;
          cs_d      = 1'b1;
          addr_d    = REG_X0;
          wr_data_d = {21'd0, x_q};
        end
      end
      S_WR_X: begin
        state_d   = S_WR_Y;
        cs_d      = 1'b1;
        addr_d    = REG_Y0;
        wr_data_d = {21'd0, y_q};
      end
      S_WR_Y:   state_d = S_FIN;
      S_WR_REG: state_d = S_FIN;
      S_UPLOAD: begin
        // Once the count is exhausted the final write is on the bus this
        // cycle, so FIN follows directly.
        if (rem_q == '0) begin
          state_d = S_FIN;
        end else if (px_valid && px_ready) begin
          cs_d                     = 1'b1;
          addr_d                   = '0;
          addr_d[ADDR_WIDTH-1:0]   = ptr_q;
          wr_data_d                = {30'd0, px_data};
          ptr_d                    = ptr_q + 1'b1;  // wraps modulo RAM size
          rem_d                    = rem_q - 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      ptr_q     <= '0;
      rem_q     <= '0;
      cs_q      <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      cs_q      <= cs_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: doc/sprite_slot_writer.md
Name: sprite_slot_writer

Overview:
- Bus initiator that drives the video-slot write interface (cs, write, addr, wr_data) of a sprite core.
- Accepts high-level commands from the processor side: set position, set ctrl, set bypass, bitmap upload.
- Turns each command into correctly addressed single-cycle slot writes. Bitmap pixels come from a valid/ready pixel stream.
- Sits between the MMIO/command logic and one sprite core's slot port.

Parameters:
- ADDR_WIDTH, 13, sprite RAM address width; RAM writes use addr[ADDR_WIDTH-1:0] with addr[13]=0.
- SYNC_POS, 1, 1 = position writes wait for frame_tick; 0 = issued immediately.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_op  in  2  0=SET_POS, 1=SET_CTRL, 2=SET_BYPASS, 3=UPLOAD
- cmd_x  in  11  x0 for SET_POS
- cmd_y  in  11  y0 for SET_POS
- cmd_val  in  5  ctrl value (SET_CTRL), bit0 = bypass (SET_BYPASS)
- cmd_base  in  ADDR_WIDTH  first RAM address (UPLOAD)
- cmd_len  in  ADDR_WIDTH+1  pixel count (UPLOAD), 0..2^ADDR_WIDTH
- px_valid  in  1  pixel present
- px_ready  out  1  pixel accepted when px_valid&px_ready
- px_data  in  2  pixel code
- cs  out  1  slot select
- write  out  1  slot write strobe (always equal to cs)
- addr  out  14  slot address
- wr_data  out  32  slot write data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on command completion

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE. cs=write=0, addr=0, wr_data=0, px_ready=0, done=0, busy=0. cmd_ready=1 in the first cycle after reset is released.
- All bus outputs are registered.
- Each write occupies exactly one cycle with cs=write=1. The slot never stalls.
- When cs=0: addr and wr_data hold their last value; write=0.
- Register map:
  - addr[13]=1, addr[12:2]=0.
  - addr[1:0]: 00 bypass, 01 x0, 10 y0, 11 ctrl.
  - RAM write: addr[13]=0, addr[12:0]=RAM address zero-extended.
- wr_data zero-extension: x0/y0 in [10:0]; ctrl in [4:0]; bypass in [0]; pixel in [1:0]. All other bits are 0.
- cmd_ready=1 only in IDLE. The command is latched at the accept edge T.
- States: IDLE, SYNC_WAIT, WR_X, WR_Y, WR_REG, UPLOAD, FIN.
- SET_POS:
  - SYNC_POS=0: write x0 in cycle T+1 (addr 0x2001), write y0 in T+2 (addr 0x2002).
  - SYNC_POS=1: go to SYNC_WAIT; on the first edge where frame_tick=1, go to WR_X. x0 and y0 are written in the two cycles after that edge.
  - A frame_tick in the accept cycle itself is ignored.
- SET_CTRL / SET_BYPASS: one write in cycle T+1 (addr 0x2003 / 0x2000). These never wait for frame_tick.
- UPLOAD:
  - px_ready=1 while in UPLOAD and remaining>0. remaining is loaded from cmd_len.
  - A pixel accepted at edge k is written in cycle k+1 to addr = (cmd_base + index) mod 2^ADDR_WIDTH. The address wraps silently.
  - Sustained rate is 1 pixel/cycle. px_valid gaps produce cs=0 cycles.
  - px_ready drops in the cycle following the last acceptance.
  - cmd_len=0: no writes, no px_ready; go straight to FIN.
- FIN:
  - Lasts one cycle, immediately after the final bus write cycle (or T+1 if there were no writes).
  - done=1 and busy=1 in FIN; the next cycle is IDLE with cmd_ready=1.
  - Minimum spacing between accepts: SET_CTRL T→T+3, SET_POS (SYNC_POS=0) T→T+4.
- Pixel stream outside UPLOAD is not consumed (px_ready=0).
- Reset asserted mid-operation (e.g., mid-upload or SYNC_WAIT):
  - The next cycle shows reset values, with no partial write or done.
  - Pending pixels are not consumed.
- cmd_val bits above those used are ignored. cmd_x, cmd_y, cmd_base and cmd_len are ignored by ops that do not use them.

Test Plan:
- Reset: hold reset=0 for 3 cycles with cmd_valid=1 -> cs=0, done=0, busy=0, no accept; after release cmd_ready=1.
- SET_POS, SYNC_POS=0, x=0x123, y=0x045, accept at T -> T+1 addr=0x2001 wr_data=0x123; T+2 addr=0x2002 wr_data=0x045; T+3 done=1; T+4 cmd_ready=1.
- SET_POS, SYNC_POS=1, frame_tick 10 cycles after accept -> no cs until the tick edge; x0 and y0 in the next two cycles; busy=1 throughout the wait.
- SET_CTRL val=5'b10110 -> one write addr=0x2003 wr_data=0x16. SET_BYPASS val=1 -> addr=0x2000 wr_data=1.
- UPLOAD base=0x1FFE len=4 with pixels 1,2,3,0 and px_valid low for 2 cycles after pixel 2 -> writes to 0x1FFE, 0x1FFF, 0x0000, 0x0001 with matching data; 2-cycle cs gap; done one cycle after the last write.
- UPLOAD len=0 -> zero writes, done at T+1. UPLOAD len=100 with reset after 40 pixels -> exactly 40 writes, no done, IDLE after reset.
